// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencing controller: FSM states, opcode/opext
// constants, instruction field positions and decode helpers.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_EXT   = 4'b1010;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_CMPU = 4'b0010;
    localparam logic [3:0] EXT_LSH  = 4'b0100;
    localparam logic [3:0] EXT_NOP  = 4'b0000;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int EXT_HI = 7;
    localparam int EXT_LO = 4;
    localparam int RS_HI  = 3;
    localparam int RS_LO  = 0;

    function automatic logic is_rtype(input logic [3:0] opc, input logic [3:0] ext);
        return (opc == OP_RTYPE) || (opc == OP_EXT) || (opc == OP_SHIFT && ext == EXT_LSH);
    endfunction

    function automatic logic is_nop(input logic [3:0] opc, input logic [3:0] ext);
        return (opc == OP_RTYPE) && (ext == EXT_NOP);
    endfunction

    // Compares and NOP leave the register file untouched.
    function automatic logic is_nowb(input logic [3:0] opc, input logic [3:0] ext);
        return (opc == OP_RTYPE && (ext == EXT_CMP || ext == EXT_NOP)) ||
               (opc == OP_CMPI) ||
               (opc == OP_EXT && ext == EXT_CMPU);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Instruction handshake between the instruction source (master) and the controller (slave).
interface alu_seq_ctrl_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (output instr, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/alu_regfile.sv
// Register file: one synchronous write port, combinational operand pair and debug reads.
module alu_regfile #(
    parameter int REGS  = 16,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic [WIDTH-1:0] dbg_data
);

    logic [REGS-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (reset)
            mem <= '0;
        else if (we)
            mem[waddr] <= wdata;
    end

    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Four-state execution controller around the combinational ALU: IDLE -> READ -> EXEC -> WB.
// Build option ALU_CTRL_IMM_SEXT_EN: sign-extend the 8-bit immediate instead of zero-extending.
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int REGS  = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_seq_ctrl_if.slave    ibus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    output logic [3:0]       alu_opext,
    input  logic [WIDTH-1:0] alu_s,
    input  logic [4:0]       alu_flags,
    output logic [4:0]       psr,
    output logic             done,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    state_t           state, nxt;
    logic [15:0]      ir;
    logic [WIDTH-1:0] op_a, op_b, res;
    logic [4:0]       flg;
    logic [WIDTH-1:0] rf_a, rf_b, imm;
    logic [3:0]       opc, rd, ext, rs;
    logic             we;

    assign opc = ir[OPC_HI:OPC_LO];
    assign rd  = ir[RD_HI:RD_LO];
    assign ext = ir[EXT_HI:EXT_LO];
    assign rs  = ir[RS_HI:RS_LO];

`ifdef ALU_CTRL_IMM_SEXT_EN
    assign imm = {{(WIDTH-8){ir[EXT_HI]}}, ir[EXT_HI:RS_LO]};
`else
    assign imm = {{(WIDTH-8){1'b0}}, ir[EXT_HI:RS_LO]};
`endif

    assign we = (state == WB) && !is_nowb(opc, ext);

    alu_regfile #(.REGS(REGS), .WIDTH(WIDTH)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (rd),
        .wdata    (res),
        .raddr_a  (rd),
        .raddr_b  (rs),
        .dbg_addr (dbg_addr),
        .rdata_a  (rf_a),
        .rdata_b  (rf_b),
        .dbg_data (dbg_data)
    );

    always_comb begin
        nxt              = state;
        ibus.instr_ready = 1'b0;
        done             = 1'b0;
        case (state)
            IDLE: begin
                ibus.instr_ready = 1'b1;
                if (ibus.instr_valid) nxt = READ;
            end
            READ: nxt = EXEC;
            EXEC: nxt = WB;
            WB: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // ALU drive registers load only on entry to EXEC, so they hold between instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ir         <= '0;
            op_a       <= '0;
            op_b       <= '0;
            res        <= '0;
            flg        <= '0;
            psr        <= '0;
            alu_opcode <= '0;
            alu_opext  <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (ibus.instr_valid) ir <= ibus.instr;
                READ: begin
                    op_a       <= rf_a;
                    op_b       <= is_rtype(opc, ext) ? rf_b : imm;
                    alu_opcode <= opc;
                    alu_opext  <= ext;
                end
                EXEC: begin
                    res <= alu_s;
                    flg <= alu_flags;
                end
                WB: if (!is_nop(opc, ext)) psr <= flg;
                default: ;
            endcase
        end
    end

    assign alu_a = op_a;
    assign alu_b = op_b;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU stub and an expected-result queue.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] alu_a, alu_b, alu_s, dbg_data;
    logic [3:0]  alu_opcode, alu_opext, dbg_addr;
    logic [4:0]  alu_flags, psr;
    logic        done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  op, ext, rd;
        logic [15:0] a, b, old, val;
        logic [4:0]  psr;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] mreg[16];
    logic [4:0]  mpsr;

    always #5 clk = ~clk;

    alu_seq_ctrl_if ibus();

    alu_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .ibus       (ibus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_opext  (alu_opext),
        .alu_s      (alu_s),
        .alu_flags  (alu_flags),
        .psr        (psr),
        .done       (done),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Stub ALU: ADD/SUB/CMP/OR/MOV/LUI subset; everything else gives 0 and no flags.
    function automatic logic [20:0] alu_fn(input logic [3:0] op, input logic [3:0] ext,
                                           input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        logic [15:0] s;
        logic [4:0]  f;
        int          kind;
        t = '0; s = '0; f = '0; kind = 0;
        if (op == 4'h0) begin
            case (ext)
                4'h5: kind = 1;
                4'h9: kind = 2;
                4'hB: kind = 3;
                4'h2: kind = 4;
                default: kind = 0;
            endcase
        end else begin
            case (op)
                4'h5: kind = 1;
                4'h9: kind = 2;
                4'hB: kind = 3;
                4'h2: kind = 4;
                4'hD: kind = 5;
                4'hF: kind = 6;
                4'hA: kind = (ext == 4'h2) ? 7 : 0;
                default: kind = 0;
            endcase
        end
        case (kind)
            1: begin
                t = {1'b0, a} + {1'b0, b}; s = t[15:0];
                f[4] = t[16]; f[2] = (a[15] == b[15]) && (s[15] != a[15]);
            end
            2: begin
                t = {1'b0, a} - {1'b0, b}; s = t[15:0];
                f[4] = t[16]; f[2] = (a[15] != b[15]) && (s[15] != a[15]);
            end
            3: begin
                f[3] = a < b; f[1] = a == b; f[0] = $signed(a) < $signed(b);
            end
            4: s = a | b;
            5: s = b;
            6: s = {b[7:0], 8'h00};
            7: begin
                f[3] = a < b; f[1] = a == b;
            end
            default: ;
        endcase
        return {f, s};
    endfunction

    always_comb {alu_flags, alu_s} = alu_fn(alu_opcode, alu_opext, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic peek(input string tag, input logic [3:0] addr, input logic [15:0] exp);
        dbg_addr = addr;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Drive an instruction, wait for acceptance, push the modelled outcome.
    task automatic issue(input logic [15:0] ins, output int waited);
        exp_t        e;
        logic [15:0] imm;
        logic [20:0] r;
        logic        rt, nowb;
        ibus.instr       = ins;
        ibus.instr_valid = 1'b1;
        waited           = 0;
        while (!ibus.instr_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!ibus.instr_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        ibus.instr_valid = 1'b0;
        e.op  = ins[15:12];
        e.rd  = ins[11:8];
        e.ext = ins[7:4];
`ifdef ALU_CTRL_IMM_SEXT_EN
        imm = {{8{ins[7]}}, ins[7:0]};
`else
        imm = {8'h00, ins[7:0]};
`endif
        rt   = (e.op == 4'h0) || (e.op == 4'hA) || (e.op == 4'h8 && e.ext == 4'h4);
        nowb = (e.op == 4'h0 && (e.ext == 4'hB || e.ext == 4'h0)) || (e.op == 4'hB) ||
               (e.op == 4'hA && e.ext == 4'h2);
        e.a   = mreg[e.rd];
        e.b   = rt ? mreg[ins[3:0]] : imm;
        r     = alu_fn(e.op, e.ext, e.a, e.b);
        e.old = mreg[e.rd];
        e.val = nowb ? e.old : r[15:0];
        mreg[e.rd] = e.val;
        if (!(e.op == 4'h0 && e.ext == 4'h0)) mpsr = r[20:16];
        e.psr = mpsr;
        sbq.push_back(e);
    endtask

    // Called from the READ cycle; follows the instruction through EXEC and WB.
    task automatic complete();
        exp_t e;
        int   lat;
        e   = sbq.pop_front();
        lat = 0;
        while (!done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                chk("exec_a", alu_a, e.a);
                chk("exec_b", alu_b, e.b);
                chk("exec_opc", alu_opcode, e.op);
                chk("exec_ext", alu_opext, e.ext);
                chk("exec_ready", ibus.instr_ready, 1'b0);
            end
        end
        chk("done_latency", lat, 2);
        chk("wb_ready", ibus.instr_ready, 1'b0);
        peek("wb_old_value", e.rd, e.old);
        @(posedge clk); #1;
        chk("done_pulse", done, 1'b0);
        chk("idle_ready", ibus.instr_ready, 1'b1);
        chk("reg_result", dbg_data, e.val);
        chk("psr", psr, e.psr);
    endtask

    task automatic run(input logic [15:0] ins);
        int w;
        issue(ins, w);
        complete();
    endtask

    initial begin
        int w;
        for (int i = 0; i < 16; i++) mreg[i] = '0;
        mpsr             = '0;
        reset            = 1'b1;
        ibus.instr       = '0;
        ibus.instr_valid = 1'b0;
        dbg_addr         = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", ibus.instr_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_psr", psr, 5'd0);
        chk("rst_alu_a", alu_a, 16'd0);
        chk("rst_alu_b", alu_b, 16'd0);
        chk("rst_alu_op", {alu_opcode, alu_opext}, 8'd0);
        peek("rst_reg7", 4'd7, 16'd0);

        run(16'h5105);                       // ADDI r1,#5
        peek("addi_r1", 4'd1, 16'h0005);
        chk("addi_psr", psr, 5'd0);

        run(16'hF180);                       // LUI r1,#80
        run(16'h9101);                       // SUBI r1,#1 -> 7FFF
        run(16'hD201);                       // MOVI r2,#1
        peek("pre_r1", 4'd1, 16'h7FFF);
        run(16'h0152);                       // ADD r1,r2
        peek("add_r1", 4'd1, 16'h8000);
        chk("add_F", psr[2], 1'b1);
        chk("add_C", psr[4], 1'b0);

        run(16'hF312);                       // LUI r3,#12
        run(16'h2334);                       // ORI r3,#34
        run(16'h03B3);                       // CMP r3,r3
        peek("cmp_r3", 4'd3, 16'h1234);
        chk("cmp_Z", psr[1], 1'b1);
        run(16'h0000);                       // NOP keeps psr
        chk("nop_psr", psr, 5'b00010);

        run(16'h94FF);                       // SUBI r4,#FF
`ifdef ALU_CTRL_IMM_SEXT_EN
        peek("subi_r4", 4'd4, 16'h0001);
`else
        peek("subi_r4", 4'd4, 16'hFF01);
`endif
        run(16'hB401);                       // CMPI r4,#1
        run(16'hA223);                       // CMPU r2,r3
        run(16'h8243);                       // unknown R-type ext: r2 <- 0, B from r3
        run(16'h7312);                       // unknown opcode: r3 <- 0
        peek("unk_r3", 4'd3, 16'h0000);

        // Second instruction held on the bus while the first is busy.
        issue(16'h5603, w);
        ibus.instr       = 16'h5604;
        ibus.instr_valid = 1'b1;
        complete();
        issue(16'h5604, w);
        chk("hold_wait", w, 0);
        complete();
        peek("hold_r6", 4'd6, 16'h0007);

        // Reset during EXEC, with instr_valid held high across reset.
        ibus.instr       = 16'hD509;
        ibus.instr_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_exec_reached", alu_opcode, 4'hD);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst2_ready", ibus.instr_ready, 1'b1);
        chk("rst2_psr", psr, 5'd0);
        chk("rst2_done", done, 1'b0);
        ibus.instr_valid = 1'b0;
        peek("rst2_r5", 4'd5, 16'h0000);
        peek("rst2_r1", 4'd1, 16'h0000);
        @(posedge clk); #1;
        peek("rst2_r5_later", 4'd5, 16'h0000);
        for (int i = 0; i < 16; i++) mreg[i] = '0;
        mpsr = '0;
        sbq.delete();

        run(16'h5105);
        peek("post_rst_r1", 4'd1, 16'h0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
